// File: rtl/axi4_bram_pkg.sv
// Shared state encodings, response codes and width helper for the AXI4 BRAM slave.
package axi4_bram_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } r_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axi4_bram_slave_if.sv
// AXI4 AW/W/B and AR/R channel bundle between the FIFO adapter and the BRAM slave.
interface axi4_bram_slave_if #(
  parameter int AXI_DATA_WIDTH = 128,
  parameter int AXI_ADDR_WIDTH = 28,
  parameter int AXI_ID_WIDTH   = 4
);
  logic [AXI_ID_WIDTH-1:0]     s_axi_awid;
  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr;
  logic [7:0]                  s_axi_awlen;
  logic                        s_axi_awvalid;
  logic                        s_axi_awready;
  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb;
  logic                        s_axi_wlast;
  logic                        s_axi_wvalid;
  logic                        s_axi_wready;
  logic [AXI_ID_WIDTH-1:0]     s_axi_bid;
  logic [1:0]                  s_axi_bresp;
  logic                        s_axi_bvalid;
  logic                        s_axi_bready;
  logic [AXI_ID_WIDTH-1:0]     s_axi_arid;
  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr;
  logic [7:0]                  s_axi_arlen;
  logic                        s_axi_arvalid;
  logic                        s_axi_arready;
  logic [AXI_ID_WIDTH-1:0]     s_axi_rid;
  logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata;
  logic [1:0]                  s_axi_rresp;
  logic                        s_axi_rlast;
  logic                        s_axi_rvalid;
  logic                        s_axi_rready;

  modport slave (
    input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bid, s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    input  s_axi_rready
  );

  modport master (
    output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    output s_axi_rready
  );

endinterface

// File: rtl/sdp_ram_be.sv
// Simple dual-port RAM: byte-enabled write port, registered read-first read port.
module sdp_ram_be
  import axi4_bram_pkg::*;
#(
  parameter int  DATA_W = 128,
  parameter int  DEPTH  = 1024,
  localparam int ADDR_W = clog2(DEPTH),
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [BE_W-1:0]   wbe_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read samples the array before this edge's write lands, giving old data on a collision.
  always_ff @(posedge clk) begin
    rdata_q <= mem_q[raddr_i];
    if (we_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wbe_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi4_bram_slave.sv
// AXI4 slave memory: independent write and read FSMs in front of a byte-enabled SDP RAM.
module axi4_bram_slave
  import axi4_bram_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 128,
  parameter int AXI_ADDR_WIDTH = 28,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int MEM_DEPTH      = 1024
) (
  input logic              clk,
  input logic              reset,
  axi4_bram_slave_if.slave s_axi
);

  localparam int OFF_W = clog2(AXI_DATA_WIDTH / 8);
  localparam int IDX_W = clog2(MEM_DEPTH);

  w_state_e                  w_state_q, w_state_d;
  r_state_e                  r_state_q, r_state_d;
  logic                      rdy_en_q;
  logic [IDX_W-1:0]          w_idx_q, w_idx_d, r_idx_q, r_idx_d;
  logic [7:0]                w_len_q, w_len_d, r_len_q, r_len_d;
  logic [7:0]                w_beat_q, w_beat_d, r_beat_q, r_beat_d;
  logic [AXI_ID_WIDTH-1:0]   w_id_q, w_id_d, r_id_q, r_id_d;
  logic                      w_err_q, w_err_d;

  logic                      awready, wready, bvalid, arready, rvalid, rlast;
  logic                      ram_we;
  logic [IDX_W-1:0]          ram_raddr;
  logic [AXI_DATA_WIDTH-1:0] ram_rdata;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_w, araddr_w;
  logic                      unused_addr;

  assign awaddr_w    = s_axi.s_axi_awaddr;
  assign araddr_w    = s_axi.s_axi_araddr;
  assign unused_addr = ^{awaddr_w, araddr_w};

  // Write channel: accept AW, absorb exactly len+1 beats, then hold B until taken.
  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    w_id_d    = w_id_q;
    w_err_d   = w_err_q;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    ram_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        awready = rdy_en_q;
        if (rdy_en_q && s_axi.s_axi_awvalid) begin
          w_idx_d   = awaddr_w[OFF_W +: IDX_W];
          w_len_d   = s_axi.s_axi_awlen;
          w_beat_d  = 8'd0;
          w_id_d    = s_axi.s_axi_awid;
          w_err_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        wready = 1'b1;
        if (s_axi.s_axi_wvalid) begin
          ram_we   = 1'b1;
          w_idx_d  = w_idx_q + IDX_W'(1);
          w_beat_d = w_beat_q + 8'd1;
          if (s_axi.s_axi_wlast != (w_beat_q == w_len_q)) w_err_d = 1'b1;
          if (w_beat_q == w_len_q) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (s_axi.s_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read channel: the RAM address runs one word ahead on each accepted beat so
  // there are no bubbles, and re-reads the same word while the master stalls.
  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_id_d    = r_id_q;
    arready   = 1'b0;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    ram_raddr = r_idx_q;
    case (r_state_q)
      R_IDLE: begin
        arready = rdy_en_q;
        if (rdy_en_q && s_axi.s_axi_arvalid) begin
          r_idx_d   = araddr_w[OFF_W +: IDX_W];
          r_len_d   = s_axi.s_axi_arlen;
          r_beat_d  = 8'd0;
          r_id_d    = s_axi.s_axi_arid;
          r_state_d = R_FETCH;
        end
      end
      R_FETCH: r_state_d = R_DATA;
      R_DATA: begin
        rvalid = 1'b1;
        rlast  = (r_beat_q == r_len_q);
        if (s_axi.s_axi_rready) begin
          ram_raddr = r_idx_q + IDX_W'(1);
          r_idx_d   = r_idx_q + IDX_W'(1);
          r_beat_d  = r_beat_q + 8'd1;
          if (rlast) r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // rdy_en_q keeps both address readies low until the first edge after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      rdy_en_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      rdy_en_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    w_idx_q  <= w_idx_d;
    w_len_q  <= w_len_d;
    w_beat_q <= w_beat_d;
    w_id_q   <= w_id_d;
    w_err_q  <= w_err_d;
    r_idx_q  <= r_idx_d;
    r_len_q  <= r_len_d;
    r_beat_q <= r_beat_d;
    r_id_q   <= r_id_d;
  end

  sdp_ram_be #(
    .DATA_W (AXI_DATA_WIDTH),
    .DEPTH  (MEM_DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (w_idx_q),
    .wbe_i   (s_axi.s_axi_wstrb),
    .wdata_i (s_axi.s_axi_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Payload fields are forced to zero whenever their valid is low.
  assign s_axi.s_axi_awready = awready;
  assign s_axi.s_axi_wready  = wready;
  assign s_axi.s_axi_bvalid  = bvalid;
  assign s_axi.s_axi_bid     = bvalid ? w_id_q : '0;
  assign s_axi.s_axi_bresp   = (bvalid && w_err_q) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi.s_axi_arready = arready;
  assign s_axi.s_axi_rvalid  = rvalid;
  assign s_axi.s_axi_rlast   = rlast;
  assign s_axi.s_axi_rid     = rvalid ? r_id_q : '0;
  assign s_axi.s_axi_rdata   = rvalid ? ram_rdata : '0;
  assign s_axi.s_axi_rresp   = RESP_OKAY;

endmodule

// File: tb/tb_axi4_bram_slave.sv
// Directed bench for axi4_bram_slave: single-beat vector table plus burst, backpressure, error, wrap and reset sequences.
`timescale 1ns/1ps
module tb_axi4_bram_slave;
  import axi4_bram_pkg::*;

  localparam int DW = 128, AW = 28, IW = 4, DEPTH = 1024, NB = DW / 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axi4_bram_slave_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW)) bus ();

  axi4_bram_slave #(
    .AXI_DATA_WIDTH (DW),
    .AXI_ADDR_WIDTH (AW),
    .AXI_ID_WIDTH   (IW),
    .MEM_DEPTH      (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .s_axi (bus)
  );

  typedef struct {
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [DW-1:0] wdata;
    logic [NB-1:0] strb;
    logic [1:0]    exp_resp;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t          vecs [6];
  logic [DW-1:0] model [DEPTH];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [1:0]    resp;
  logic [DW-1:0] first;
  logic [DW-1:0] base;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int widx(input logic [AW-1:0] a);
    return int'(a >> 4) % DEPTH;
  endfunction

  task automatic model_wr(input int idx, input logic [DW-1:0] d, input logic [NB-1:0] s);
    for (int b = 0; b < NB; b++) begin
      if (s[b]) model[idx % DEPTH][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  task automatic idle_inputs();
    bus.s_axi_awid = '0; bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0; bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0; bus.s_axi_wvalid = 1'b0;
    bus.s_axi_bready = 1'b0;
    bus.s_axi_arid = '0; bus.s_axi_araddr = '0; bus.s_axi_arlen = '0; bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, bus.s_axi_awready, 0);
    check({tag, "_wready"},  bus.s_axi_wready, 0);
    check({tag, "_bvalid"},  bus.s_axi_bvalid, 0);
    check({tag, "_bresp"},   bus.s_axi_bresp, 0);
    check({tag, "_bid"},     bus.s_axi_bid, 0);
    check({tag, "_arready"}, bus.s_axi_arready, 0);
    check({tag, "_rvalid"},  bus.s_axi_rvalid, 0);
    check({tag, "_rlast"},   bus.s_axi_rlast, 0);
    check({tag, "_rid"},     bus.s_axi_rid, 0);
    check({tag, "_rdata"},   bus.s_axi_rdata, 0);
  endtask

  // Beat i carries base+i; last_at<0 means wlast on the true final beat.
  task automatic axi_write(input logic [AW-1:0] addr, input logic [7:0] len, input logic [IW-1:0] id,
                           input logic [DW-1:0] b0, input logic [NB-1:0] strb, input int last_at,
                           input bit rnd_b, output logic [1:0] bresp_o);
    int n, idx, dly;
    logic [DW-1:0] d;
    idx = widx(addr);
    bus.s_axi_awid = id; bus.s_axi_awaddr = addr; bus.s_axi_awlen = len; bus.s_axi_awvalid = 1'b1;
    n = 0;
    while (!bus.s_axi_awready && n < 20) begin tick(); n++; end
    check("awready", bus.s_axi_awready, 1);
    tick();
    bus.s_axi_awvalid = 1'b0;
    check("wready_after_aw", bus.s_axi_wready, 1);
    for (int i = 0; i <= int'(len); i++) begin
      d = b0 + DW'(i);
      bus.s_axi_wdata  = d;
      bus.s_axi_wstrb  = strb;
      bus.s_axi_wlast  = (last_at >= 0) ? (i == last_at) : (i == int'(len));
      bus.s_axi_wvalid = 1'b1;
      check("wready_beat", bus.s_axi_wready, 1);
      tick();
      model_wr(idx + i, d, strb);
    end
    bus.s_axi_wvalid = 1'b0;
    bus.s_axi_wlast  = 1'b0;
    check("bvalid_after_last_w", bus.s_axi_bvalid, 1);
    if (rnd_b) begin
      dly = $urandom_range(0, 3);
      for (int k = 0; k < dly; k++) begin
        tick();
        check("bvalid_held", bus.s_axi_bvalid, 1);
      end
    end
    bus.s_axi_bready = 1'b1;
    check("bid", bus.s_axi_bid, id);
    bresp_o = bus.s_axi_bresp;
    tick();
    bus.s_axi_bready = 1'b0;
    check("bvalid_after_b", bus.s_axi_bvalid, 0);
    check("awready_after_b", bus.s_axi_awready, 1);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input logic [7:0] len, input logic [IW-1:0] id,
                          input bit rnd, output logic [DW-1:0] first_o);
    int n, idx, beat, cyc;
    bit rdy, stalled;
    logic [DW-1:0] held;
    idx = widx(addr);
    first_o = '0;
    held = '0;
    bus.s_axi_arid = id; bus.s_axi_araddr = addr; bus.s_axi_arlen = len; bus.s_axi_arvalid = 1'b1;
    n = 0;
    while (!bus.s_axi_arready && n < 20) begin tick(); n++; end
    check("arready", bus.s_axi_arready, 1);
    tick();
    bus.s_axi_arvalid = 1'b0;
    check("rvalid_fetch", bus.s_axi_rvalid, 0);
    tick();
    check("rvalid_first", bus.s_axi_rvalid, 1);
    beat = 0; cyc = 0; stalled = 1'b0;
    while (beat <= int'(len) && cyc < 400) begin
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.s_axi_rready = rdy;
      if (stalled) check("rdata_stable", bus.s_axi_rdata, held);
      if (!rnd) check("r_no_bubble", bus.s_axi_rvalid, 1);
      stalled = 1'b0;
      if (bus.s_axi_rvalid && rdy) begin
        check($sformatf("rdata_b%0d", beat), bus.s_axi_rdata, model[(idx + beat) % DEPTH]);
        check($sformatf("rlast_b%0d", beat), bus.s_axi_rlast, (beat == int'(len)));
        check("rid", bus.s_axi_rid, id);
        if (beat == 0) first_o = bus.s_axi_rdata;
        beat++;
      end else if (bus.s_axi_rvalid) begin
        stalled = 1'b1;
        held = bus.s_axi_rdata;
      end
      tick();
      cyc++;
    end
    bus.s_axi_rready = 1'b0;
    check("r_beats", beat, int'(len) + 1);
    check("rvalid_after_r", bus.s_axi_rvalid, 0);
    check("arready_after_r", bus.s_axi_arready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{28'h40,   28'h40, {16{8'hA5}}, 16'hFFFF, RESP_OKAY, {16{8'hA5}}};
    vecs[1] = '{28'h50,   28'h50, {16{8'hFF}}, 16'hFFFF, RESP_OKAY, {16{8'hFF}}};
    vecs[2] = '{28'h50,   28'h50, 128'h11223344_55667788_99AABBCC_DDEEFF00, 16'h000F, RESP_OKAY,
                128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_DDEEFF00};
    vecs[3] = '{28'h55,   28'h50, 128'h0, 16'hFFFF, RESP_OKAY, 128'h0};
    vecs[4] = '{28'h5F,   28'h50, {16{8'h77}}, 16'hC000, RESP_OKAY,
                128'h7777_0000_0000_0000_0000_0000_0000_0000};
    vecs[5] = '{28'h4070, 28'h70, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 16'hFFFF, RESP_OKAY,
                128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF};

    reset = 1'b1;
    idle_inputs();
    repeat (3) tick();
    check_all_zero("in_reset");
    reset = 1'b0;
    check("awready_before_edge", bus.s_axi_awready, 0);
    tick();
    check("awready_after_reset", bus.s_axi_awready, 1);
    check("arready_after_reset", bus.s_axi_arready, 1);

    for (int i = 0; i < 6; i++) begin
      axi_write(vecs[i].waddr, 8'd0, IW'(i), vecs[i].wdata, vecs[i].strb, -1, 1'b0, resp);
      check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
      axi_read(vecs[i].raddr, 8'd0, IW'(i + 8), 1'b0, first);
      check($sformatf("vec%0d_rdata", i), first, vecs[i].exp_rdata);
    end

    // 32-beat burst, incrementing data, full-rate read.
    base = 128'h0000C0DE_11110000_22220000_33330000;
    axi_write(28'h1000, 8'd31, 4'h3, base, 16'hFFFF, -1, 1'b0, resp);
    check("burst32_bresp", resp, RESP_OKAY);
    axi_read(28'h1000, 8'd31, 4'h4, 1'b0, first);
    check("burst32_first", first, base);

    // 16 beats with random bready and rready stalls.
    base = 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D300;
    axi_write(28'h2000, 8'd15, 4'h9, base, 16'hFFFF, -1, 1'b1, resp);
    check("bp16_bresp", resp, RESP_OKAY);
    axi_read(28'h2000, 8'd15, 4'hA, 1'b1, first);
    check("bp16_first", first, base);

    // Early wlast: all four beats still land, response is SLVERR.
    base = 128'h5555AAAA_5555AAAA_5555AAAA_55550000;
    axi_write(28'h3100, 8'd3, 4'h2, base, 16'hFFFF, 2, 1'b0, resp);
    check("wlast_err_bresp", resp, RESP_SLVERR);
    axi_read(28'h3100, 8'd3, 4'h2, 1'b0, first);
    check("wlast_err_first", first, base);

    // Start at word DEPTH-2: words 1022, 1023, 0, 1.
    base = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABC0000;
    axi_write(28'h3FE0, 8'd3, 4'h1, base, 16'hFFFF, -1, 1'b0, resp);
    check("wrap_bresp", resp, RESP_OKAY);
    axi_read(28'h3FE0, 8'd3, 4'h1, 1'b0, first);
    check("wrap_first", first, base);
    axi_read(28'h0, 8'd0, 4'h0, 1'b0, first);
    check("wrap_word0", first, base + 128'd2);
    axi_read(28'h10, 8'd0, 4'h0, 1'b0, first);
    check("wrap_word1", first, base + 128'd3);

    // Concurrent 32-beat write and read, reset asserted while beat 5 is presented.
    base = 128'h77770000_66660000_55550000_44440000;
    bus.s_axi_awid = 4'h5; bus.s_axi_awaddr = 28'h3000; bus.s_axi_awlen = 8'd31; bus.s_axi_awvalid = 1'b1;
    bus.s_axi_arid = 4'h6; bus.s_axi_araddr = 28'h1000; bus.s_axi_arlen = 8'd31; bus.s_axi_arvalid = 1'b1;
    check("rst_seq_awready", bus.s_axi_awready, 1);
    check("rst_seq_arready", bus.s_axi_arready, 1);
    tick();
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.s_axi_wdata = base + DW'(i); bus.s_axi_wstrb = 16'hFFFF; bus.s_axi_wlast = 1'b0;
      bus.s_axi_wvalid = 1'b1; bus.s_axi_rready = 1'b1;
      tick();
      model_wr(widx(28'h3000) + i, base + DW'(i), 16'hFFFF);
    end
    check("rst_seq_rvalid_active", bus.s_axi_rvalid, 1);
    bus.s_axi_wdata = base + DW'(5);
    reset = 1'b1;
    #1;
    check_all_zero("mid_reset");
    idle_inputs();
    tick();
    tick();
    check("held_reset_awready", bus.s_axi_awready, 0);
    check("held_reset_arready", bus.s_axi_arready, 0);
    reset = 1'b0;
    tick();
    check("post_reset_awready", bus.s_axi_awready, 1);
    check("post_reset_arready", bus.s_axi_arready, 1);
    bus.s_axi_bready = 1'b1;
    bus.s_axi_rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("dropped_no_b", bus.s_axi_bvalid, 0);
      check("dropped_no_r", bus.s_axi_rvalid, 0);
      tick();
    end
    bus.s_axi_bready = 1'b0;
    bus.s_axi_rready = 1'b0;

    base = 128'h13579BDF_2468ACE0_FEDCBA98_76540000;
    axi_write(28'h3200, 8'd3, 4'h7, base, 16'hFFFF, -1, 1'b0, resp);
    check("after_reset_bresp", resp, RESP_OKAY);
    axi_read(28'h3200, 8'd3, 4'h8, 1'b0, first);
    check("after_reset_first", first, base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi4_bram_slave.md
# axi4_bram_slave

Synthesizable single-clock AXI4 slave memory backed by a byte-enabled simple dual-port RAM. It sits directly downstream of the FIFO/AXI4 adapter, in place of the DDR3 controller. It terminates the adapter's AW/W/B and AR/R channels so the write-FIFO → AXI → read-FIFO path can be brought up in simulation and on small FPGAs without a memory controller. Write and read channels are independent and may be active at the same time.

## Interface
Parameters:
- AXI_DATA_WIDTH, 128: data width in bits; a power of two, 32 or more.
- AXI_ADDR_WIDTH, 28: byte-address width.
- AXI_ID_WIDTH, 4: ID width.
- MEM_DEPTH, 1024: RAM depth in AXI_DATA_WIDTH-bit words; a power of two.

Ports:
- clk, in, 1: single clock. All logic is on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- s_axi_awid / awaddr / awlen / awvalid, in, ID / ADDR / 8 / 1: write address channel.
- s_axi_awready, out, 1: write address ready.
- s_axi_wdata / wstrb / wlast / wvalid, in, DATA / DATA/8 / 1 / 1: write data channel.
- s_axi_wready, out, 1: write data ready.
- s_axi_bid / bresp / bvalid, out, ID / 2 / 1: write response channel.
- s_axi_bready, in, 1: write response ready.
- s_axi_arid / araddr / arlen / arvalid, in, ID / ADDR / 8 / 1: read address channel.
- s_axi_arready, out, 1: read address ready.
- s_axi_rid / rdata / rresp / rlast / rvalid, out, ID / DATA / 2 / 1 / 1: read data channel.
- s_axi_rready, in, 1: read data ready.

The master's awsize, awburst, lock, cache, prot, qos and region outputs (and the AR equivalents) are left unconnected. Bursts are always treated as INCR at full data width.

## Operation
**Addressing**
- Word index = addr >> log2(AXI_DATA_WIDTH/8), taken modulo MEM_DEPTH.
- The index increments by 1 per beat and wraps from MEM_DEPTH-1 to 0 with no error.

**Write FSM** (W_IDLE, W_DATA, W_RESP)
- W_IDLE:
  - awready=1.
  - On AW handshake, latch id, start index and len; clear the beat count; go to W_DATA.
- W_DATA:
  - wready=1.
  - Each W handshake writes wdata into the current index, gated per byte by wstrb.
  - The index and beat count increment on every handshake.
  - The handshake with beat count == len goes to W_RESP.
  - A wlast mismatch (wlast high on an earlier beat, or low on the final beat) sets an error flag. The burst still consumes exactly len+1 beats.
- W_RESP:
  - bvalid=1, bid = latched id.
  - bresp = 2'b10 (SLVERR) if the error flag is set, else 2'b00.
  - Held until bready, then go to W_IDLE.

**Read FSM** (R_IDLE, R_FETCH, R_DATA)
- R_IDLE:
  - arready=1.
  - On AR handshake, latch id, index and len; go to R_FETCH.
- R_FETCH: a one-cycle RAM read of the first word; go to R_DATA.
- R_DATA:
  - rvalid=1, rid = latched id, rresp = 2'b00.
  - rlast=1 when beat count == len.
  - rdata is the RAM registered output.
  - RAM read address = index+1 when an R handshake occurs, else index. This gives full throughput with no bubbles and keeps rdata stable while rready is low.
  - The handshake with rlast goes to R_IDLE.

**Collisions and reset**
- Same-cycle read and write to the same word: the read returns the old data (read-first).
- A write is visible to an R_FETCH or prefetch issued on the following cycle.
- Reset mid-burst: both FSMs go to idle and the outstanding transaction is dropped with no B or R response. RAM contents are not reset.

## Timing
- All outputs are registered or decoded from registered state. Reset value of every output is 0, including awready and arready.
- awready and arready rise on the first clk edge after reset falls.
- Write: AW handshake at cycle T → wready at T+1. Final W handshake at cycle U → bvalid at U+1.
- Read: AR handshake at cycle T → first rvalid at T+2. With rready held high, consecutive beats follow every cycle.
- Minimum gap between bursts on one channel: back to idle 1 cycle after the closing handshake, so the next AW/AR can be accepted on that cycle.
- No combinational path from any input to any ready or valid output.

## Structure
- Package axi4_bram_pkg holds:
  - the write and read state encodings;
  - localparams RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - a clog2 function for the index and byte-lane widths.
- Sub-module sdp_ram_be: simple dual-port RAM with one write port (per-byte enables) and one read port with a registered output (read-first), parameterised by width and depth.

## Test plan
- Single beat: awaddr=0x40, awlen=0, wdata=0xA5..A5, full wstrb → bresp=0 at U+1. Then araddr=0x40, arlen=0 → rdata=0xA5..A5, rlast=1 at T+2.
- Burst of 32 (awlen=31, the adapter default), incrementing data → read back 32 beats in order, one per cycle with rready held high, rlast only on beat 31.
- Random rready and bready backpressure, in 50% of cycles, on a 16-beat read → rdata stable while stalled; no lost or duplicated beats.
- Partial strobe: write wstrb=0x000F over an all-0xFF word → read returns 0xFF..FF with bytes 0-3 replaced by the new data.
- wlast asserted on beat 2 of awlen=3 → all 4 beats written, bresp=SLVERR. Index wrap: start index MEM_DEPTH-2 with len=3 writes words MEM_DEPTH-2, MEM_DEPTH-1, 0, 1.
- Assert reset during beat 5 of a 32-beat write and read → all outputs 0 while reset is high; awready and arready return after reset falls; no B or R response for the dropped bursts; a following burst completes correctly.
